// File: rtl/jogo_sequencia_param_pkg.sv
// Shared definitions for the parameterised sequence-memory game:
// FSM state encoding and the default move sequence.
package jogo_sequencia_param_pkg;

  typedef enum logic [3:0] {
    INICIAL        = 4'd0,
    PREPARA        = 4'd1,
    INICIA_RODADA  = 4'd2,
    ESPERA_JOGADA  = 4'd3,
    REGISTRA       = 4'd4,
    COMPARA        = 4'd5,
    PROXIMA_JOGADA = 4'd6,
    PROXIMA_RODADA = 4'd7,
    FIM_ACERTO     = 4'd8,
    FIM_ERRO       = 4'd9,
    FIM_TIMEOUT    = 4'd10
  } estado_t;

  localparam int unsigned SEQ_BASE_LEN = 16;

  // Button index of sequence entry pos; the 16-entry base pattern repeats
  // and is folded onto the available buttons.
  function automatic int unsigned seq_indice(input int unsigned pos,
                                             input int unsigned n_botoes);
    int unsigned base;
    case (pos % SEQ_BASE_LEN)
      0:       base = 0;
      1:       base = 1;
      2:       base = 2;
      3:       base = 3;
      4:       base = 2;
      5:       base = 1;
      6:       base = 0;
      7:       base = 0;
      8:       base = 1;
      9:       base = 1;
      10:      base = 2;
      11:      base = 2;
      12:      base = 3;
      13:      base = 3;
      14:      base = 0;
      15:      base = 2;
      default: base = 0;
    endcase
    return base % n_botoes;
  endfunction

endpackage

// File: rtl/sequencia_rom.sv
// Read-only sequence table: one-hot expected move for each position,
// read combinationally by move index.
module sequencia_rom
  import jogo_sequencia_param_pkg::*;
#(
  parameter int unsigned N_BOTOES     = 4,
  parameter int unsigned PROFUNDIDADE = 16
) (
  input  logic [$clog2(PROFUNDIDADE)-1:0] endereco,
  output logic [N_BOTOES-1:0]             jogada_esperada
);

  localparam int unsigned AW = $clog2(PROFUNDIDADE);

  always_comb begin
    jogada_esperada = '0;
    for (int unsigned i = 0; i < PROFUNDIDADE; i++) begin
      if (endereco == AW'(i))
        jogada_esperada = N_BOTOES'(1) << seq_indice(i, N_BOTOES);
    end
  end

endmodule

// File: rtl/jogo_sequencia_param.sv
// Sequence-memory game: round r asks the player to repeat sequence entries
// 0..r; ends on full success, wrong move or (optionally) move timeout.
module jogo_sequencia_param
  import jogo_sequencia_param_pkg::*;
#(
  parameter int unsigned N_BOTOES       = 4,
  parameter int unsigned PROFUNDIDADE   = 16,
  parameter int unsigned TIMEOUT_CICLOS = 3000
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            iniciar,
  input  logic                            modo,
  input  logic [N_BOTOES-1:0]             chaves,
  output logic [N_BOTOES-1:0]             leds,
  output logic                            pronto,
  output logic                            acertou,
  output logic                            errou,
  output logic                            timeout,
  output logic [$clog2(PROFUNDIDADE)-1:0] db_rodada,
  output logic [$clog2(PROFUNDIDADE)-1:0] db_endereco,
  output logic [3:0]                      db_estado
);

  localparam int unsigned AW = $clog2(PROFUNDIDADE);
  localparam int unsigned CW = $clog2(TIMEOUT_CICLOS + 1);

  estado_t             estado;
  logic [AW-1:0]       rodada;
  logic [AW-1:0]       endereco;
  logic [CW-1:0]       contador;
  logic                modo_reg;
  logic [N_BOTOES-1:0] chaves_ant;
  logic [N_BOTOES-1:0] jogada_cap;
  logic [N_BOTOES-1:0] jogada_esperada;
  logic                jogada;
  logic                fim;

  sequencia_rom #(
    .N_BOTOES     (N_BOTOES),
    .PROFUNDIDADE (PROFUNDIDADE)
  ) u_rom (
    .endereco        (endereco),
    .jogada_esperada (jogada_esperada)
  );

  assign jogada = (|chaves) && !(|chaves_ant);
  assign fim    = (estado == FIM_ACERTO) || (estado == FIM_ERRO) ||
                  (estado == FIM_TIMEOUT);

  always_ff @(posedge clock) begin
    if (reset) begin
      estado     <= INICIAL;
      rodada     <= '0;
      endereco   <= '0;
      contador   <= '0;
      modo_reg   <= 1'b0;
      leds       <= '0;
      chaves_ant <= '0;
      jogada_cap <= '0;
      pronto     <= 1'b0;
      acertou    <= 1'b0;
      errou      <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      chaves_ant <= chaves;
      // The move value is captured on its press edge so a one-cycle press
      // is still registered correctly one state later.
      if (jogada)
        jogada_cap <= chaves;

      case (estado)
        INICIAL, FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
          // Clearing on entry makes PREPARA already show a clean game.
          if (iniciar) begin
            estado   <= PREPARA;
            rodada   <= '0;
            endereco <= '0;
            leds     <= '0;
            pronto   <= 1'b0;
            acertou  <= 1'b0;
            errou    <= 1'b0;
            timeout  <= 1'b0;
          end
        end
        PREPARA: begin
          modo_reg <= modo;
          estado   <= INICIA_RODADA;
        end
        INICIA_RODADA: begin
          endereco <= '0;
          contador <= '0;
          estado   <= ESPERA_JOGADA;
        end
        ESPERA_JOGADA: begin
          if (jogada) begin
            estado <= REGISTRA;
          end else if (contador == CW'(TIMEOUT_CICLOS - 1)) begin
            // Counter saturates here; it only ends the game when enabled.
            if (modo_reg) begin
              estado  <= FIM_TIMEOUT;
              pronto  <= 1'b1;
              errou   <= 1'b1;
              timeout <= 1'b1;
            end
          end else begin
            contador <= contador + CW'(1);
          end
        end
        REGISTRA: begin
          leds   <= jogada_cap;
          estado <= COMPARA;
        end
        COMPARA: begin
          if (leds != jogada_esperada) begin
            estado <= FIM_ERRO;
            pronto <= 1'b1;
            errou  <= 1'b1;
          end else if (endereco < rodada) begin
            estado <= PROXIMA_JOGADA;
          end else if (rodada == AW'(PROFUNDIDADE - 1)) begin
            estado  <= FIM_ACERTO;
            pronto  <= 1'b1;
            acertou <= 1'b1;
          end else begin
            estado <= PROXIMA_RODADA;
          end
        end
        PROXIMA_JOGADA: begin
          endereco <= endereco + AW'(1);
          contador <= '0;
          estado   <= ESPERA_JOGADA;
        end
        PROXIMA_RODADA: begin
          rodada <= rodada + AW'(1);
          estado <= INICIA_RODADA;
        end
        default: estado <= INICIAL;
      endcase
    end
  end

  assign db_rodada   = rodada;
  assign db_endereco = endereco;
  assign db_estado   = estado;

endmodule

// File: doc/jogo_sequencia_param.md
JOGO_SEQUENCIA_PARAM -- requirements
Module: jogo_sequencia_param

Interface
REQ-001 Parameter N_BOTOES, default 4, number of buttons/LEDs (2..8).
REQ-002 Parameter PROFUNDIDADE, default 16, maximum rounds and sequence length (2..64).
REQ-003 Parameter TIMEOUT_CICLOS, default 3000, clock cycles allowed per move.
REQ-004 Port clock  in  1  single system clock; all state updates on rising edge.
REQ-005 Port reset  in  1  synchronous, active-high reset.
REQ-006 Port iniciar  in  1  start/restart request, level-sampled.
REQ-007 Port modo  in  1  timeout enable (1 = timeout active), latched at start.
REQ-008 Port chaves  in  N_BOTOES  player buttons, expected one-hot.
REQ-009 Port leds  out  N_BOTOES  last registered move.
REQ-010 Port pronto, acertou, errou, timeout  out  1 each  end-of-game flags.
REQ-011 Port db_rodada  out  clog2(PROFUNDIDADE)  current round index.
REQ-012 Port db_endereco  out  clog2(PROFUNDIDADE)  current move index within round.
REQ-013 Port db_estado  out  4  FSM state encoding.

Function
REQ-014 FSM states SHALL be INICIAL, PREPARA, INICIA_RODADA, ESPERA_JOGADA, REGISTRA, COMPARA, PROXIMA_JOGADA, PROXIMA_RODADA, FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT; each non-wait state lasts exactly one cycle.
REQ-015 INICIAL->PREPARA when iniciar=1; PREPARA clears rodada, endereco, leds, latches modo.
REQ-016 INICIA_RODADA clears endereco and timeout counter, then ESPERA_JOGADA.
REQ-017 Move detect: one-cycle pulse when chaves goes from all-zero (previous cycle) to non-zero; holding buttons yields no further pulses.
REQ-018 ESPERA_JOGADA->REGISTRA on move pulse; REGISTRA stores chaves into leds register.
REQ-019 COMPARA: stored move != sequencia[endereco] (including any multi-bit value) -> FIM_ERRO.
REQ-020 COMPARA match, endereco<rodada -> PROXIMA_JOGADA (endereco+1, timeout cleared) -> ESPERA_JOGADA.
REQ-021 COMPARA match, endereco==rodada, rodada==PROFUNDIDADE-1 -> FIM_ACERTO; otherwise PROXIMA_RODADA (rodada+1) -> INICIA_RODADA.
REQ-022 Timeout counter increments each cycle in ESPERA_JOGADA; at TIMEOUT_CICLOS-1 with latched modo=1 -> FIM_TIMEOUT; move pulse in same cycle takes priority.
REQ-023 With latched modo=0 the counter SHALL saturate and never force FIM_TIMEOUT.
REQ-024 pronto=1 in all FIM_* states; acertou=1 only in FIM_ACERTO; errou=1 in FIM_ERRO and FIM_TIMEOUT; timeout=1 only in FIM_TIMEOUT.
REQ-025 FIM_* states hold until iniciar=1, then PREPARA (full restart, flags drop next cycle).
REQ-026 iniciar SHALL be ignored in all states except INICIAL and FIM_*.
REQ-027 Moves arriving outside ESPERA_JOGADA SHALL be discarded.

Reset
REQ-028 reset=1 at any clock edge -> INICIAL, rodada=0, endereco=0, timeout counter=0, leds=0, all flags 0, latched modo=0; overrides iniciar and moves, mid-game included.

Structure
REQ-029 Shared package SHALL hold state encoding constants and the default sequence table (one-hot indices 0,1,2,3,2,1,0,0,1,1,2,2,3,3,0,2, repeated modulo N_BOTOES to PROFUNDIDADE).
REQ-030 Sequence storage SHALL be sub-module sequencia_rom (PROFUNDIDADE x N_BOTOES, combinational read by endereco).
REQ-031 Counters and FSM SHALL reside in jogo_sequencia_param; no derived clocks.

Verification
REQ-032 Defaults, modo=0, correct full game (round r plays entries 0..r) -> acertou=1, pronto=1, db_rodada=15, errou=0.
REQ-033 Round 3 (db_rodada=2), second move 0100 instead of 0010 -> FIM_ERRO, errou=1, acertou=0, db_endereco=1.
REQ-034 modo=1, no press for 3000 cycles in ESPERA_JOGADA -> timeout=1, errou=1; modo=0, 10000 idle cycles -> still ESPERA_JOGADA.
REQ-035 chaves=0011 as first move -> FIM_ERRO; held 0001 across 5 cycles counts as one move.
REQ-036 From FIM_ACERTO, iniciar pulse -> PREPARA, flags 0, db_rodada=0; replayed game ends acertou=1; reset in round 5 -> INICIAL next cycle, all outputs 0.
REQ-037 N_BOTOES=6, PROFUNDIDADE=4, TIMEOUT_CICLOS=20 -> correct game ends FIM_ACERTO at db_rodada=3; idle 20 cycles with modo=1 -> FIM_TIMEOUT.
